// File: rtl/ysyx_23060061_ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time over a
// valid/ready memory port, hands it to decode, then waits for the next PC.
module ysyx_23060061_ifu #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h80000000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  input  logic            npc_valid,
  input  logic [XLEN-1:0] npc,
  input  logic            halt,
  output logic            halted,
  output logic            fetch_err
);

  typedef enum logic [2:0] {
    REQ,
    RESP,
    VALID,
    WAIT_PC,
    HALT
  } state_t;

  state_t          state, stateNext;
  logic [XLEN-1:0] pc, pcNext;
  logic [31:0]     instReg, instNext;
  logic [XLEN-1:0] instPcReg, instPcNext;
  logic            fetchErr, errNext;
  logic            pendHalt, pendNext;

  // State and datapath registers; everything clears asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      instReg   <= '0;
      instPcReg <= RESET_PC;
      fetchErr  <= 1'b0;
      pendHalt  <= 1'b0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      instReg   <= instNext;
      instPcReg <= instPcNext;
      fetchErr  <= errNext;
      pendHalt  <= pendNext;
    end
  end

  // Next-state logic; halt takes priority over every other event except an
  // accepted request, which must still see its response before stopping.
  always_comb begin
    stateNext  = state;
    pcNext     = pc;
    instNext   = instReg;
    instPcNext = instPcReg;
    errNext    = fetchErr;
    pendNext   = pendHalt;
    case (state)
      REQ: begin
        if (imem_req_ready) begin
          stateNext = RESP;
          pendNext  = halt;
        end else if (halt) begin
          stateNext = HALT;
        end
      end
      RESP: begin
        if (imem_rsp_valid) begin
          pendNext = 1'b0;
          // A halt seen on the response cycle is treated like a pending one.
          if (pendHalt || halt) begin
            stateNext = HALT;
          end else if (imem_rsp_err) begin
            errNext   = 1'b1;
            stateNext = HALT;
          end else begin
            instNext   = imem_rsp_data;
            instPcNext = pc;
            stateNext  = VALID;
          end
        end else if (halt) begin
          pendNext = 1'b1;
        end
      end
      VALID: begin
        if (halt)            stateNext = HALT;
        else if (inst_ready) stateNext = WAIT_PC;
      end
      WAIT_PC: begin
        if (halt) begin
          stateNext = HALT;
        end else if (npc_valid) begin
          if (npc[1:0] != 2'b00) begin
            errNext   = 1'b1;
            stateNext = HALT;
          end else begin
            pcNext    = npc;
            stateNext = REQ;
          end
        end
      end
      default: stateNext = HALT;
    endcase
  end

  // The request is masked while rst is held so no valid is seen during reset.
  assign imem_req_valid = (state == REQ) && !rst;
  assign imem_addr      = pc;
  assign inst_valid     = (state == VALID);
  assign halted         = (state == HALT);
  assign fetch_err      = fetchErr;
  assign inst           = instReg;
  assign inst_pc        = instPcReg;
  assign opcode         = instReg[6:0];
  assign funct3         = instReg[14:12];
  assign funct7         = instReg[31:25];

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// Self-checking bench for the fetch unit: directed scenarios plus a randomized
// run, all compared against a transaction-level model of the fetch protocol.
module tb_ysyx_23060061_ifu;

  localparam logic [31:0] RPC = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        imem_rsp_err = 1'b0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        npc_valid = 1'b0;
  logic [31:0] npc = '0;
  logic        halt = 1'b0;
  logic        halted, fetch_err;

  int checks = 0;
  int failures = 0;
  int reqCount = 0;

  ysyx_23060061_ifu #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .npc_valid(npc_valid), .npc(npc), .halt(halt),
    .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Environment view of the single outstanding fetch transaction.
  typedef enum {M_FETCH, M_MEMWAIT, M_OFFER, M_NPCWAIT, M_STOP} phase_t;
  phase_t      mPhase = M_FETCH;
  logic [31:0] mPc = RPC, mInst = '0, mInstPc = RPC;
  bit          mErr = 0, mDrop = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs that were applied
  // during the cycle that just ended.
  task automatic modelStep();
    if (rst) begin
      mPhase = M_FETCH; mPc = RPC; mInst = '0; mInstPc = RPC; mErr = 0; mDrop = 0;
      return;
    end
    case (mPhase)
      M_FETCH:
        if (imem_req_ready) begin mPhase = M_MEMWAIT; mDrop = halt; end
        else if (halt) mPhase = M_STOP;
      M_MEMWAIT:
        if (imem_rsp_valid) begin
          if (mDrop || halt) mPhase = M_STOP;
          else if (imem_rsp_err) begin mErr = 1; mPhase = M_STOP; end
          else begin mInst = imem_rsp_data; mInstPc = mPc; mPhase = M_OFFER; end
          mDrop = 0;
        end else if (halt) mDrop = 1;
      M_OFFER:
        if (halt) mPhase = M_STOP;
        else if (inst_ready) mPhase = M_NPCWAIT;
      M_NPCWAIT:
        if (halt) mPhase = M_STOP;
        else if (npc_valid) begin
          if (npc % 4 != 0) begin mErr = 1; mPhase = M_STOP; end
          else begin mPc = npc; mPhase = M_FETCH; end
        end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelStep();
  endtask

  // Compare process: every cycle, mid-period, check all outputs.
  always @(negedge clk) begin
    if (imem_req_valid && imem_req_ready) reqCount++;
    if (rst) begin
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, RPC);
      chk("rst_addr", imem_addr, RPC);
    end else begin
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, mPhase == M_FETCH});
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, mPhase == M_OFFER});
      chk("halted", {31'b0, halted}, {31'b0, mPhase == M_STOP});
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, mErr});
      chk("imem_addr", imem_addr, mPc);
      chk("inst", inst, mInst);
      chk("inst_pc", inst_pc, mInstPc);
      chk("opcode", {25'b0, opcode}, mInst % 128);
      chk("funct3", {29'b0, funct3}, (mInst / 4096) % 8);
      chk("funct7", {25'b0, funct7}, mInst / 33554432);
    end
  end

  task automatic doReset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  // One complete fetch: request, good response, accept, next PC.
  task automatic fetchOne(input logic [31:0] data, input logic [31:0] nextPc);
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = data; tick();
    imem_rsp_valid = 1'b0; inst_ready = 1'b1; tick();
    inst_ready = 1'b0; npc_valid = 1'b1; npc = nextPc; tick();
    npc_valid = 1'b0;
  endtask

  initial begin
    int base;
    // Reset and first fetch.
    repeat (3) tick();
    rst = 1'b0; #1;
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_addr", imem_addr, 32'h80000000);
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00100093; tick();
    imem_rsp_valid = 1'b0;
    chk("first_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("first_opcode", {25'b0, opcode}, 32'h13);
    chk("first_funct3", {29'b0, funct3}, 32'd0);
    chk("first_inst_pc", inst_pc, 32'h80000000);
    inst_ready = 1'b1; tick();
    inst_ready = 1'b0; npc_valid = 1'b1; npc = 32'h80000004; tick();
    npc_valid = 1'b0;
    chk("seq_addr", imem_addr, 32'h80000004);
    chk("seq_req_valid", {31'b0, imem_req_valid}, 32'd1);

    // Backpressure on both sides; exactly one request for this fetch.
    base = reqCount;
    repeat (4) tick();
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hfe010113; tick();
    imem_rsp_valid = 1'b0;
    repeat (5) tick();
    chk("bp_inst_hold", inst, 32'hfe010113);
    chk("bp_pc_hold", inst_pc, 32'h80000004);
    chk("bp_one_request", reqCount - base, 32'd1);
    inst_ready = 1'b1; tick();
    inst_ready = 1'b0; npc_valid = 1'b1; npc = 32'h80000100; tick();
    npc_valid = 1'b0;
    chk("jump_addr", imem_addr, 32'h80000100);
    chk("jump_req_valid", {31'b0, imem_req_valid}, 32'd1);

    // Response fault.
    imem_req_ready = 1'b1; tick();
    imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; tick();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    base = reqCount;
    repeat (3) tick();
    imem_req_ready = 1'b0;
    chk("rsperr_fetch_err", {31'b0, fetch_err}, 32'd1);
    chk("rsperr_halted", {31'b0, halted}, 32'd1);
    chk("rsperr_no_req", reqCount - base, 32'd0);

    // Misaligned next PC.
    doReset();
    fetchOne(32'h00000013, 32'h80000002);
    chk("misalign_fetch_err", {31'b0, fetch_err}, 32'd1);
    chk("misalign_halted", {31'b0, halted}, 32'd1);

    // halt together with npc_valid.
    doReset();
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000073; tick();
    imem_rsp_valid = 1'b0; inst_ready = 1'b1; tick();
    inst_ready = 1'b0; npc_valid = 1'b1; npc = 32'h80000004; halt = 1'b1; tick();
    npc_valid = 1'b0; halt = 1'b0;
    chk("haltnpc_halted", {31'b0, halted}, 32'd1);
    chk("haltnpc_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("haltnpc_err", {31'b0, fetch_err}, 32'd0);

    // halt during RESP; faulty response discarded later.
    doReset();
    fetchOne(32'h12345013, 32'h80000008);
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0; halt = 1'b1; tick();
    halt = 1'b0; tick(); tick();
    imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'hdeadbeef; tick();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    chk("pend_halted", {31'b0, halted}, 32'd1);
    chk("pend_no_err", {31'b0, fetch_err}, 32'd0);
    chk("pend_inst_kept", inst, 32'h12345013);

    // Asynchronous reset in the middle of RESP, then a stale response.
    doReset();
    fetchOne(32'h00a00513, 32'h80000010);
    imem_req_ready = 1'b1; tick();
    imem_req_ready = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1; #1;
    chk("async_addr", imem_addr, RPC);
    chk("async_inst", inst, 32'd0);
    chk("async_inst_pc", inst_pc, RPC);
    chk("async_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();
    rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0badf00d; tick();
    imem_rsp_valid = 1'b0;
    chk("stale_inst", inst, 32'd0);
    chk("stale_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("restart_addr", imem_addr, 32'h80000000);
    chk("restart_req_valid", {31'b0, imem_req_valid}, 32'd1);

    // Randomized traffic, including ignored inputs in every phase.
    for (int i = 0; i < 4000; i++) begin
      if (rst) rst = 1'b0;
      else if ((mPhase == M_STOP && $urandom_range(3) == 0) || $urandom_range(299) == 0) rst = 1'b1;
      imem_req_ready = $urandom_range(1);
      imem_rsp_valid = $urandom_range(1);
      imem_rsp_data  = $urandom;
      imem_rsp_err   = ($urandom_range(15) == 0);
      inst_ready     = $urandom_range(1);
      npc_valid      = $urandom_range(1);
      npc            = {$urandom_range(32'hffff) , 16'h0} | ($urandom & 32'hfffc);
      if ($urandom_range(15) == 0) npc[1:0] = 2'($urandom_range(1, 3));
      halt           = ($urandom_range(49) == 0);
      tick();
    end
    rst = 1'b0; halt = 1'b0; imem_rsp_valid = 1'b0; npc_valid = 1'b0;
    tick();
    @(negedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
